// File: rtl/process_element_pkg.sv
// Shared widths, types and saturation helpers for process-element datapaths.
// Latency: none (package only).
// Backpressure: not applicable.
package process_element_pkg;

    localparam int IN_W    = 22;
    localparam int ACC_W   = 32;
    localparam int BIAS_W  = 16;
    localparam int SHIFT_W = 5;
    localparam int OUT_W   = 8;

    typedef logic signed [IN_W-1:0]   prod_t;
    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic signed [ACC_W:0]    wide_t;   // one guard bit for overflow detection
    typedef logic signed [BIAS_W-1:0] bias_t;
    typedef logic signed [OUT_W-1:0]  res_t;

    localparam acc_t  ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam acc_t  ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
    localparam res_t  OUT_MAX  = {1'b0, {(OUT_W-1){1'b1}}};
    localparam res_t  OUT_MIN  = {1'b1, {(OUT_W-1){1'b0}}};
    localparam wide_t WOUT_MAX = wide_t'(OUT_MAX);
    localparam wide_t WOUT_MIN = wide_t'(OUT_MIN);

    // Result registered in S1, waiting for the requant stage.
    typedef struct packed {
        acc_t               sum;
        logic [SHIFT_W-1:0] shift;
        logic               relu;
        logic               sat;
    } s1_t;

    // A guard-bit value overflowed ACC_W when the top two bits disagree.
    function automatic logic acc_ovf(input wide_t v);
        return v[ACC_W] ^ v[ACC_W-1];
    endfunction

    function automatic acc_t acc_clamp(input wide_t v);
        if (acc_ovf(v)) begin
            return v[ACC_W] ? ACC_MIN : ACC_MAX;
        end
        return v[ACC_W-1:0];
    endfunction

endpackage

// File: rtl/process_element_requant_sat.sv
// Round-half-up arithmetic right shift, optional ReLU, clip to OUT_W signed.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
// Ports: sum/shift/relu in; data (clipped result) and clip flag out.
module process_element_requant_sat
    import process_element_pkg::*;
(
    input  logic [ACC_W-1:0]   sum,
    input  logic [SHIFT_W-1:0] shift,
    input  logic               relu,
    output logic [OUT_W-1:0]   data,
    output logic               clip
);

    acc_t  sum_s;
    wide_t sum_w;
    wide_t rnd;
    wide_t rsum;
    wide_t r_shift;
    wide_t r_relu;
    logic  hi;
    logic  lo;

    assign sum_s = sum;
    assign sum_w = wide_t'(sum_s);
    // Half an LSB of the shifted result; a zero shift takes the sum unchanged.
    assign rnd   = (shift == '0) ? '0 : (wide_t'(1) << (shift - 5'd1));
    // The guard bit absorbs the rounding carry at the positive limit.
    assign rsum    = sum_w + rnd;
    assign r_shift = rsum >>> shift;
    assign r_relu  = (relu && r_shift[ACC_W]) ? '0 : r_shift;

    assign hi   = r_relu > WOUT_MAX;
    assign lo   = r_relu < WOUT_MIN;
    assign clip = hi | lo;
    assign data = hi ? OUT_MAX : (lo ? OUT_MIN : r_relu[OUT_W-1:0]);

endmodule

// File: rtl/process_element_acc_requant.sv
// Accumulates signed products per vector, then adds bias, requantizes and saturates to int8.
// Latency: last beat accepted at cycle t -> out_valid at cycle t+2.
// Backpressure: holds two results (S1 + output reg); in_ready drops when both are full and out_ready=0.
// Ports: clk/reset (async active-low); in_* product stream with cfg_* sampled on the last beat;
//        out_valid/out_ready/out_data/out_sat result handshake.
module process_element_acc_requant
    import process_element_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_data,
    input  logic               in_last,
    input  logic [BIAS_W-1:0]  cfg_bias,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic               cfg_relu,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_sat
);

    acc_t  acc;
    logic  acc_sat;
    s1_t   s1;
    logic  s1_valid;
    s1_t   s1_nxt;

    prod_t prod;
    bias_t bias;
    wide_t acc_sum_w;
    acc_t  acc_sum;
    wide_t bias_sum_w;
    logic  in_fire;
    logic  s2_move;

    logic [OUT_W-1:0] rq_data;
    logic             rq_clip;

    assign in_ready = !s1_valid || !out_valid || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign s2_move  = s1_valid && (!out_valid || out_ready);

    assign prod       = in_data;
    assign bias       = cfg_bias;
    assign acc_sum_w  = wide_t'(acc) + wide_t'(prod);
    assign acc_sum    = acc_clamp(acc_sum_w);
    assign bias_sum_w = wide_t'(acc_sum) + wide_t'(bias);

    always_comb begin
        s1_nxt       = '0;
        s1_nxt.sum   = acc_clamp(bias_sum_w);
        s1_nxt.shift = cfg_shift;
        s1_nxt.relu  = cfg_relu;
        s1_nxt.sat   = acc_sat | acc_ovf(acc_sum_w) | acc_ovf(bias_sum_w);
    end

    // Accumulator restarts from zero after every last beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc     <= '0;
            acc_sat <= 1'b0;
        end else if (in_fire) begin
            if (in_last) begin
                acc     <= '0;
                acc_sat <= 1'b0;
            end else begin
                acc     <= acc_sum;
                acc_sat <= acc_sat | acc_ovf(acc_sum_w);
            end
        end
    end

    // A load and a move can coincide; the load wins and keeps S1 full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else if (in_fire && in_last) begin
            s1_valid <= 1'b1;
            s1       <= s1_nxt;
        end else if (s2_move) begin
            s1_valid <= 1'b0;
        end
    end

    process_element_requant_sat u_requant (
        .sum   (s1.sum),
        .shift (s1.shift),
        .relu  (s1.relu),
        .data  (rq_data),
        .clip  (rq_clip)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (s2_move) begin
            out_valid <= 1'b1;
            out_data  <= rq_data;
            out_sat   <= s1.sat | rq_clip;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_process_element_acc_requant.sv
module tb_process_element_acc_requant;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [21:0] in_data = '0;
    logic        in_last = 1'b0;
    logic [15:0] cfg_bias = '0;
    logic [4:0]  cfg_shift = '0;
    logic        cfg_relu = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic        out_sat;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [8:0] res_q[$];
    int         cyc_q[$];

    always #5 clk = ~clk;

    process_element_acc_requant dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .cfg_bias  (cfg_bias),
        .cfg_shift (cfg_shift),
        .cfg_relu  (cfg_relu),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    // Pre-edge values are seen here, before the design's registers update.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset && out_valid && out_ready) begin
            res_q.push_back({out_sat, out_data});
            cyc_q.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    task automatic send_beat(input int data, input bit last, input int bias,
                             input int shift, input bit relu);
        int budget;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = data[21:0];
        in_last   = last;
        cfg_bias  = bias[15:0];
        cfg_shift = shift[4:0];
        cfg_relu  = relu;
        #1;
        budget = 0;
        while (!in_ready && budget < 200) begin
            @(negedge clk);
            #1;
            budget++;
        end
        if (!in_ready) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic get_result(output int d, output int s);
        int budget;
        budget = 0;
        while (res_q.size() == 0 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (res_q.size() == 0) begin
            chk("result_timeout", 0, 1);
            d = 9999;
            s = 9999;
        end else begin
            logic [8:0] r;
            r = res_q.pop_front();
            void'(cyc_q.pop_front());
            d = int'($signed(r[7:0]));
            s = int'(r[8]);
        end
    endtask

    task automatic expect_result(input string tag, input int exp_d, input int exp_s);
        int d;
        int s;
        get_result(d, s);
        chk({tag, "_data"}, d, exp_d);
        chk({tag, "_sat"}, s, exp_s);
    endtask

    initial begin
        int d1, s1, d2, s2, d3, s3, c1, c2, c3;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_sat", int'(out_sat), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        reset = 1'b1;
        @(negedge clk);

        // Basic: 100 - 30 + 50 = 120, +10 = 130, (130+2)>>>2 = 33; latency t+2
        send_beat(100, 0, 10, 2, 0);
        send_beat(-30, 0, 10, 2, 0);
        send_beat(50, 1, 10, 2, 0);
        @(negedge clk);
        chk("lat_t1_out_valid", int'(out_valid), 0);
        @(negedge clk);
        chk("lat_t2_out_valid", int'(out_valid), 1);
        expect_result("basic", 33, 0);

        // ReLU zeroes the negative, no saturation; without ReLU clip to -128
        send_beat(-500, 1, 0, 0, 1);
        expect_result("relu_on", 0, 0);
        send_beat(-500, 1, 0, 0, 0);
        expect_result("relu_off", -128, 1);

        // Negative rounding, half-up
        send_beat(-6, 1, 0, 2, 0);
        expect_result("neg_m6_s2", -1, 0);
        send_beat(-7, 1, 0, 1, 0);
        expect_result("neg_m7_s1", -3, 0);

        // Backpressure: two results buffered, third last beat held
        @(negedge clk);
        out_ready = 1'b0;
        send_beat(1, 1, 0, 0, 0);
        send_beat(2, 1, 0, 0, 0);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 22'd3;
        in_last   = 1'b1;
        cfg_shift = '0;
        cfg_bias  = '0;
        #1;
        chk("bp_in_ready_low", int'(in_ready), 0);
        repeat (3) @(negedge clk);
        #1;
        chk("bp_in_ready_still_low", int'(in_ready), 0);
        chk("bp_out_valid_held", int'(out_valid), 1);
        chk("bp_out_data_held", int'(out_data), 1);
        chk("bp_no_pops", res_q.size(), 0);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_release", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (4) @(negedge clk);
        chk("bp_pop_count", res_q.size(), 3);
        if (cyc_q.size() >= 3) begin
            c1 = cyc_q[0];
            c2 = cyc_q[1];
            c3 = cyc_q[2];
            chk("bp_gap_12", c2 - c1, 1);
            chk("bp_gap_23", c3 - c2, 1);
        end
        get_result(d1, s1);
        get_result(d2, s2);
        get_result(d3, s3);
        chk("bp_order_1", d1, 1);
        chk("bp_order_2", d2, 2);
        chk("bp_order_3", d3, 3);
        chk("bp_sat_any", s1 | s2 | s3, 0);

        // Accumulator saturation, then a fresh vector
        for (int i = 0; i < 1100; i++) send_beat(2097151, 0, 0, 0, 0);
        send_beat(0, 1, 0, 0, 0);
        expect_result("accsat", 127, 1);
        send_beat(5, 1, 0, 0, 0);
        expect_result("after_accsat", 5, 0);

        // Reset mid-vector discards the partial sum
        send_beat(1000, 0, 0, 0, 0);
        send_beat(1000, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        @(negedge clk);
        chk("midrst_out_valid_2", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        reset = 1'b1;
        send_beat(5, 1, 0, 0, 0);
        expect_result("midrst_fresh", 5, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
